card_pile: RTL and testbench

CARD_PILE -- requirements
Module: card_pile

---
 rtl/card_pile_if.sv | 46 ++++
 rtl/card_pile.sv | 196 +++++++++++++++++++
 tb/tb_card_pile.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/card_pile_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : card_pile_if                                          |
// | Brief    : Handshake and status bundle for the card_pile block   |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
interface card_pile_if #(
  parameter int DEPTH  = 108,
  parameter int CARD_W = 6
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              i_seed_valid;
  logic [15:0]       i_seed;
  logic              i_load_valid;
  logic [CARD_W-1:0] i_load_card;
  logic              o_load_ready;
  logic              i_start;
  logic              i_draw_req;
  logic [2:0]        i_draw_n;
  logic              o_card_valid;
  logic [CARD_W-1:0] o_card;
  logic              i_disc_valid;
  logic [CARD_W-1:0] i_disc_card;
  logic              o_disc_ready;
  logic [CARD_W-1:0] o_top;
  logic [CNT_W-1:0]  o_draw_cnt;
  logic [CNT_W-1:0]  o_disc_cnt;
  logic              o_busy;
  logic              o_short;

  modport master (
    output i_seed_valid, i_seed, i_load_valid, i_load_card, i_start,
           i_draw_req, i_draw_n, i_disc_valid, i_disc_card,
    input  o_load_ready, o_card_valid, o_card, o_disc_ready, o_top,
           o_draw_cnt, o_disc_cnt, o_busy, o_short
  );

  modport slave (
    input  i_seed_valid, i_seed, i_load_valid, i_load_card, i_start,
           i_draw_req, i_draw_n, i_disc_valid, i_disc_card,
    output o_load_ready, o_card_valid, o_card, o_disc_ready, o_top,
           o_draw_cnt, o_disc_cnt, o_busy, o_short
  );
endinterface
`default_nettype wire

// File: rtl/card_pile.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : card_pile                                             |
// | Brief    : Draw/discard card piles with LFSR shuffle, multi-card |
// |            deal and automatic recycle of the discard pile        |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module card_pile #(
  parameter int DEPTH    = 108,
  parameter int CARD_W   = 6,
  parameter int MAX_DRAW = 4,
  parameter int KEEP_TOP = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  card_pile_if.slave   bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [2:0]       MAX_N   = 3'(MAX_DRAW);
  localparam logic [CNT_W-1:0] KEEP_C  = CNT_W'(KEEP_TOP);
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SHUFFLE, DEAL, RECYCLE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  draw_cnt_q, draw_cnt_d;
  logic [CNT_W-1:0]  disc_cnt_q, disc_cnt_d;
  logic [2:0]        rem_q, rem_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic [CNT_W-1:0]  j_q, j_d;
  logic [15:0]       lfsr_q, lfsr_d;

  // Pile storage; contents are never reset.
  logic [CARD_W-1:0] draw_mem [DEPTH];
  logic [CARD_W-1:0] disc_mem [DEPTH];

  // Array write controls: two draw ports (for the swap), one discard port.
  logic              dw0_en, dw1_en, cw_en;
  logic [IDX_W-1:0]  dw0_addr, dw1_addr, cw_addr;
  logic [CARD_W-1:0] dw0_data, dw1_data, cw_data;
  logic              card_valid_w, short_w;

  logic [IDX_W-1:0]  draw_top_idx, disc_top_idx, rnd;
  logic [CNT_W:0]    total;
  logic              disc_ready_w, load_ready_w, draw_ok;

  assign draw_top_idx = IDX_W'(draw_cnt_q - CNT_W'(1));
  assign disc_top_idx = IDX_W'(disc_cnt_q - CNT_W'(1));
  assign rnd          = lfsr_q[IDX_W-1:0];
  assign total        = {1'b0, draw_cnt_q} + {1'b0, disc_cnt_q};
  assign disc_ready_w = (state_q == IDLE) && !bus.i_start && !bus.i_draw_req && (total < DEPTH_C);
  assign load_ready_w = disc_ready_w && !bus.i_disc_valid;
  assign draw_ok      = bus.i_draw_req && (bus.i_draw_n != 3'd0) && (bus.i_draw_n <= MAX_N);

  // LFSR next value: free-running x^16+x^14+x^13+x^11+1, seed load overrides.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    if (bus.i_seed_valid) begin
      lfsr_d = (bus.i_seed == 16'h0000) ? 16'hACE1 : bus.i_seed;
    end
  end

  // Next-state, counter and array-write decode for the pile controller.
  always_comb begin
    state_d      = state_q;
    draw_cnt_d   = draw_cnt_q;
    disc_cnt_d   = disc_cnt_q;
    rem_d        = rem_q;
    k_d          = k_q;
    j_d          = j_q;
    dw0_en       = 1'b0;
    dw0_addr     = '0;
    dw0_data     = '0;
    dw1_en       = 1'b0;
    dw1_addr     = '0;
    dw1_data     = '0;
    cw_en        = 1'b0;
    cw_addr      = '0;
    cw_data      = '0;
    card_valid_w = 1'b0;
    short_w      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          // With zero or one card, k starts at 0 and SHUFFLE exits at once.
          k_d     = (draw_cnt_q == '0) ? '0 : draw_top_idx;
          state_d = SHUFFLE;
        end else if (draw_ok) begin
          rem_d   = bus.i_draw_n;
          state_d = DEAL;
        end else if (bus.i_disc_valid && disc_ready_w) begin
          cw_en      = 1'b1;
          cw_addr    = IDX_W'(disc_cnt_q);
          cw_data    = bus.i_disc_card;
          disc_cnt_d = disc_cnt_q + CNT_W'(1);
        end else if (bus.i_load_valid && load_ready_w) begin
          dw0_en     = 1'b1;
          dw0_addr   = IDX_W'(draw_cnt_q);
          dw0_data   = bus.i_load_card;
          draw_cnt_d = draw_cnt_q + CNT_W'(1);
        end
      end
      SHUFFLE: begin
        // Fisher-Yates: out-of-range candidates are simply retried.
        if (k_q == '0) begin
          state_d = (rem_q != 3'd0) ? DEAL : IDLE;
        end else if (rnd <= k_q) begin
          dw0_en   = 1'b1;
          dw0_addr = k_q;
          dw0_data = draw_mem[rnd];
          dw1_en   = 1'b1;
          dw1_addr = rnd;
          dw1_data = draw_mem[k_q];
          k_d      = k_q - IDX_W'(1);
        end
      end
      DEAL: begin
        if (rem_q == 3'd0) begin
          state_d = IDLE;
        end else if (draw_cnt_q != '0) begin
          card_valid_w = 1'b1;
          draw_cnt_d   = draw_cnt_q - CNT_W'(1);
          rem_d        = rem_q - 3'd1;
          if (rem_q == 3'd1) state_d = IDLE;
        end else if (disc_cnt_q > KEEP_C) begin
          j_d     = '0;
          state_d = RECYCLE;
        end else begin
          short_w = 1'b1;
          rem_d   = 3'd0;
          state_d = IDLE;
        end
      end
      RECYCLE: begin
        // Draw pile is empty on entry, so copies land at index j.
        dw0_en     = 1'b1;
        dw0_addr   = IDX_W'(draw_cnt_q);
        dw0_data   = disc_mem[IDX_W'(j_q)];
        draw_cnt_d = draw_cnt_q + CNT_W'(1);
        j_d        = j_q + CNT_W'(1);
        if (j_q == disc_cnt_q - CNT_W'(1) - KEEP_C) begin
          if (KEEP_TOP != 0) begin
            cw_en   = 1'b1;
            cw_addr = '0;
            cw_data = disc_mem[disc_top_idx];
          end
          disc_cnt_d = KEEP_C;
          k_d        = IDX_W'(draw_cnt_q);
          state_d    = SHUFFLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      draw_cnt_q <= '0;
      disc_cnt_q <= '0;
      rem_q      <= 3'd0;
      k_q        <= '0;
      j_q        <= '0;
      lfsr_q     <= 16'hACE1;
    end else begin
      state_q    <= state_d;
      draw_cnt_q <= draw_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      rem_q      <= rem_d;
      k_q        <= k_d;
      j_q        <= j_d;
      lfsr_q     <= lfsr_d;
    end
  end

  // Pile array writes.
  always_ff @(posedge i_clk) begin
    if (dw0_en) draw_mem[dw0_addr] <= dw0_data;
    if (dw1_en) draw_mem[dw1_addr] <= dw1_data;
    if (cw_en)  disc_mem[cw_addr]  <= cw_data;
  end

  // Strobes are masked by reset so an aborted deal emits nothing further.
  assign bus.o_card_valid = card_valid_w && !i_rst;
  assign bus.o_short      = short_w && !i_rst;
  assign bus.o_card       = draw_mem[draw_top_idx];
  assign bus.o_top        = (disc_cnt_q == '0) ? '0 : disc_mem[disc_top_idx];
  assign bus.o_draw_cnt   = draw_cnt_q;
  assign bus.o_disc_cnt   = disc_cnt_q;
  assign bus.o_busy       = (state_q != IDLE);
  assign bus.o_disc_ready = disc_ready_w;
  assign bus.o_load_ready = load_ready_w;
endmodule
`default_nettype wire

// File: tb/tb_card_pile.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_card_pile                                          |
// | Brief    : Directed self-checking bench for card_pile            |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_card_pile;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   cyc;
  int   short_cnt;
  logic [5:0] got_q [$];
  int         got_cyc [$];
  logic [5:0] ord [2][8];

  card_pile_if #(.DEPTH(8), .CARD_W(6)) bus ();

  card_pile #(.DEPTH(8), .CARD_W(6), .MAX_DRAW(4), .KEEP_TOP(1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter, advanced on the active edge.
  always @(posedge clk) cyc++;

  // Capture dealt cards and short pulses away from the active edge.
  always @(negedge clk) begin
    if (bus.o_card_valid === 1'b1) begin
      got_q.push_back(bus.o_card);
      got_cyc.push_back(cyc);
    end
    if (bus.o_short === 1'b1) short_cnt++;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (bus.o_busy === 1'b1 && b < 400) begin
      tick();
      b++;
    end
    check("idle_timeout", {31'd0, bus.o_busy}, 0);
  endtask

  task automatic load_card(input logic [5:0] c);
    bus.i_load_valid = 1'b1;
    bus.i_load_card  = c;
    tick();
    bus.i_load_valid = 1'b0;
  endtask

  task automatic push_disc(input logic [5:0] c);
    bus.i_disc_valid = 1'b1;
    bus.i_disc_card  = c;
    tick();
    bus.i_disc_valid = 1'b0;
  endtask

  task automatic draw(input logic [2:0] n);
    bus.i_draw_req = 1'b1;
    bus.i_draw_n   = n;
    tick();
    bus.i_draw_req = 1'b0;
    wait_idle();
  endtask

  initial begin
    int c0;
    int mask;
    int diff;
    n_tests = 0;
    n_fail = 0;
    cyc = 0;
    short_cnt = 0;
    rst = 1'b1;
    bus.i_seed_valid = 1'b0;
    bus.i_seed       = 16'h0;
    bus.i_load_valid = 1'b0;
    bus.i_load_card  = '0;
    bus.i_start      = 1'b0;
    bus.i_draw_req   = 1'b0;
    bus.i_draw_n     = 3'd0;
    bus.i_disc_valid = 1'b0;
    bus.i_disc_card  = '0;

    // Reset state
    do_reset();
    check("rst_draw_cnt", 32'(bus.o_draw_cnt), 0);
    check("rst_disc_cnt", 32'(bus.o_disc_cnt), 0);
    check("rst_busy", {31'd0, bus.o_busy}, 0);
    check("rst_top", 32'(bus.o_top), 0);
    check("rst_card_valid", {31'd0, bus.o_card_valid}, 0);
    check("rst_load_ready", {31'd0, bus.o_load_ready}, 1);

    // Scenario 1: unshuffled draw of 3 from 0..7
    for (int i = 0; i < 8; i++) load_card(6'(i));
    check("s1_draw_cnt", 32'(bus.o_draw_cnt), 8);
    check("s1_full_disc_ready", {31'd0, bus.o_disc_ready}, 0);
    check("s1_full_load_ready", {31'd0, bus.o_load_ready}, 0);
    got_q.delete();
    got_cyc.delete();
    c0 = cyc;
    draw(3'd3);
    check("s1_ncards", 32'(got_q.size()), 3);
    if (got_q.size() == 3) begin
      check("s1_card0", 32'(got_q[0]), 7);
      check("s1_card1", 32'(got_q[1]), 6);
      check("s1_card2", 32'(got_q[2]), 5);
      check("s1_cyc0", 32'(got_cyc[0]), 32'(c0 + 1));
      check("s1_cyc1", 32'(got_cyc[1]), 32'(c0 + 2));
      check("s1_cyc2", 32'(got_cyc[2]), 32'(c0 + 3));
    end
    check("s1_draw_cnt_after", 32'(bus.o_draw_cnt), 5);

    // Scenario 2: seeded shuffle is a permutation and is repeatable
    for (int run = 0; run < 2; run++) begin
      do_reset();
      for (int i = 0; i < 8; i++) load_card(6'(i));
      bus.i_seed_valid = 1'b1;
      bus.i_seed       = 16'h1234;
      tick();
      bus.i_seed_valid = 1'b0;
      bus.i_start      = 1'b1;
      tick();
      bus.i_start      = 1'b0;
      check("s2_busy", {31'd0, bus.o_busy}, 1);
      wait_idle();
      got_q.delete();
      draw(3'd4);
      draw(3'd4);
      check("s2_ncards", 32'(got_q.size()), 8);
      mask = 0;
      for (int i = 0; i < 8; i++) begin
        if (i < got_q.size()) begin
          ord[run][i] = got_q[i];
          if (got_q[i] < 8) mask = mask | (1 << got_q[i]);
        end else begin
          ord[run][i] = 6'h3F;
        end
      end
      check("s2_permutation", 32'(mask), 32'hFF);
    end
    diff = 0;
    for (int i = 0; i < 8; i++) if (ord[0][i] !== ord[1][i]) diff++;
    check("s2_repeat_diff", 32'(diff), 0);

    // Scenario 3: deal runs dry, recycles discard pile keeping top
    do_reset();
    load_card(6'd5);
    bus.i_disc_valid = 1'b1;
    bus.i_disc_card  = 6'd10;
    #1;
    check("s3_disc_ready", {31'd0, bus.o_disc_ready}, 1);
    check("s3_load_ready_blocked", {31'd0, bus.o_load_ready}, 0);
    tick();
    bus.i_disc_valid = 1'b0;
    push_disc(6'd11);
    push_disc(6'd12);
    check("s3_top", 32'(bus.o_top), 12);
    check("s3_disc_cnt", 32'(bus.o_disc_cnt), 3);
    got_q.delete();
    draw(3'd3);
    check("s3_ncards", 32'(got_q.size()), 3);
    if (got_q.size() == 3) begin
      check("s3_card0", 32'(got_q[0]), 5);
      check("s3_recycled_pair",
            {31'd0, ((got_q[1] == 6'd10 && got_q[2] == 6'd11) ||
                     (got_q[1] == 6'd11 && got_q[2] == 6'd10))}, 1);
    end
    check("s3_disc_cnt_after", 32'(bus.o_disc_cnt), 1);
    check("s3_top_after", 32'(bus.o_top), 12);
    check("s3_draw_cnt_after", 32'(bus.o_draw_cnt), 0);

    // Scenario 4: nothing to recycle -> short pulse
    got_q.delete();
    short_cnt = 0;
    draw(3'd2);
    tick();
    check("s4_short_pulses", 32'(short_cnt), 1);
    check("s4_ncards", 32'(got_q.size()), 0);
    check("s4_busy", {31'd0, bus.o_busy}, 0);

    // Scenario 5: full piles, start wins over draw request
    do_reset();
    for (int i = 0; i < 4; i++) load_card(6'(i));
    for (int i = 0; i < 4; i++) push_disc(6'(20 + i));
    check("s5_total", 32'(bus.o_draw_cnt) + 32'(bus.o_disc_cnt), 8);
    check("s5_disc_ready", {31'd0, bus.o_disc_ready}, 0);
    check("s5_load_ready", {31'd0, bus.o_load_ready}, 0);
    got_q.delete();
    bus.i_start    = 1'b1;
    bus.i_draw_req = 1'b1;
    bus.i_draw_n   = 3'd2;
    tick();
    bus.i_start    = 1'b0;
    bus.i_draw_req = 1'b0;
    check("s5_busy", {31'd0, bus.o_busy}, 1);
    wait_idle();
    tick();
    check("s5_no_cards", 32'(got_q.size()), 0);
    check("s5_draw_cnt", 32'(bus.o_draw_cnt), 4);

    // Scenario 6: reset mid-deal
    do_reset();
    for (int i = 0; i < 8; i++) load_card(6'(i));
    got_q.delete();
    bus.i_draw_req = 1'b1;
    bus.i_draw_n   = 3'd4;
    tick();
    bus.i_draw_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("s6_busy", {31'd0, bus.o_busy}, 0);
    check("s6_draw_cnt", 32'(bus.o_draw_cnt), 0);
    check("s6_disc_cnt", 32'(bus.o_disc_cnt), 0);
    check("s6_card_valid", {31'd0, bus.o_card_valid}, 0);
    rst = 1'b0;
    tick();
    tick();
    check("s6_ncards", 32'(got_q.size()), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
